// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop rx synchroniser, mid-bit sampling, stop-bit check,
// and a one-entry holding register with a valid/ack handshake and sticky overrun.
module uart_rx #(
   parameter int unsigned CLOCK_DIV = 104  // bit period is CLOCK_DIV+1 clocks; must be >= 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   input  logic       rx_ack,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       framing_error,
   output logic       overrun,
   output logic       busy
);

   localparam logic [15:0] Half = 16'(CLOCK_DIV / 2);
   localparam logic [15:0] Div  = 16'(CLOCK_DIV);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        rx_meta_q, rx_s_q;
   logic        deliver;
   logic        fe_set;

   // Idle-high synchroniser; only rx_s_q feeds any decision.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         count_q   <= 16'd0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'd0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q + 16'd1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      deliver   = 1'b0;
      fe_set    = 1'b0;
      unique case (state_q)
         StIdle: begin
            count_d = 16'd0;
            if (!rx_s_q) state_d = StStart;
         end
         StStart: begin
            // Re-check at mid start bit so a short glitch drops back to idle silently.
            if (count_q == Half) begin
               count_d = 16'd0;
               if (!rx_s_q) begin
                  state_d   = StData;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StData: begin
            if (count_q == Div) begin
               count_d           = 16'd0;
               shift_d[bit_idx_q] = rx_s_q;
               if (bit_idx_q == 3'd7) state_d = StStop;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end
         end
         StStop: begin
            if (count_q == Div) begin
               count_d = 16'd0;
               if (rx_s_q) begin
                  deliver = 1'b1;
                  state_d = StIdle;
               end else begin
                  fe_set  = 1'b1;
                  state_d = StBreak;
               end
            end
         end
         StBreak: begin
            // Hold here while the line is low so a break cannot look like a new start bit.
            count_d = 16'd0;
            if (rx_s_q) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            count_d = 16'd0;
         end
      endcase
   end

   assign busy = (state_q != StIdle);

   always_ff @(posedge clock) begin
      if (reset) begin
         data_out      <= 8'd0;
         data_valid    <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         framing_error <= fe_set;
         if (deliver) begin
            // Newest byte always wins; an ack on the same cycle consumes the old one.
            data_out   <= shift_q;
            data_valid <= 1'b1;
            if (rx_ack)          overrun <= 1'b0;
            else if (data_valid) overrun <= 1'b1;
         end else if (rx_ack && data_valid) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
         end
      end
   end

endmodule
